lifting_rotator: RTL

//  Plane rotation of a sample pair (x1,x2) by a runtime-selected angle, built from 3 lifting steps
//  (tan/2, sin, tan/2). Angle is chosen per beat from a coefficient table; per-beat forward/inverse select.

---
 rtl/lifting_rotator.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/lifting_rotator.sv
// Three-stage lifting plane rotator (tan/2, sin, tan/2) with per-beat angle and direction.
// Valid/ready pipeline with guard bits, round-to-nearest products and saturated outputs.
module lifting_rotator #(
   parameter int DATA_W     = 16,
   parameter int POINT      = 14,
   parameter int COEF_W     = 16,
   parameter int GUARD_BITS = 2,
   parameter int NUM_ANGLES = 2,
   parameter logic [NUM_ANGLES*COEF_W-1:0] TAN_COEFS = {16'sd6787, 16'sd0},
   parameter logic [NUM_ANGLES*COEF_W-1:0] SIN_COEFS = {16'sd11585, 16'sd0},
   parameter int SIDE_W     = 1,
   localparam int ASW       = (NUM_ANGLES > 1) ? $clog2(NUM_ANGLES) : 1
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     s_valid_i,
   output logic                     s_ready_o,
   input  logic signed [DATA_W-1:0] s_x1_i,
   input  logic signed [DATA_W-1:0] s_x2_i,
   input  logic [ASW-1:0]           s_angle_sel_i,
   input  logic                     s_inverse_i,
   input  logic [SIDE_W-1:0]        s_side_data_i,
   output logic                     m_valid_o,
   input  logic                     m_ready_i,
   output logic signed [DATA_W-1:0] m_y1_o,
   output logic signed [DATA_W-1:0] m_y2_o,
   output logic                     m_sat_o,
   output logic [SIDE_W-1:0]        m_side_data_o
);

   localparam int IW    = DATA_W + GUARD_BITS + 1;
   localparam int PW    = IW + COEF_W;
   localparam int GB_M1 = (GUARD_BITS > 0) ? GUARD_BITS - 1 : 0;

   localparam logic signed [PW-1:0] MUL_HALF  = PW'(2 ** (POINT - 1));
   localparam logic signed [IW:0]   EXIT_HALF = (GUARD_BITS > 0) ? (IW+1)'(2 ** GB_M1) : '0;
   localparam logic signed [IW:0]   OUT_MAX   = (IW+1)'(2 ** (DATA_W - 1) - 1);
   localparam logic signed [IW:0]   OUT_MIN   = (IW+1)'(-(2 ** (DATA_W - 1)));

   function automatic logic signed [IW-1:0] mul_round(input logic signed [IW-1:0]     a,
                                                      input logic signed [COEF_W-1:0] c);
      logic signed [PW-1:0] p;
      p = PW'(a) * PW'(c) + MUL_HALF;
      return IW'(p >>> POINT);
   endfunction

   function automatic logic signed [DATA_W-1:0] exit_sat(input  logic signed [IW-1:0] v,
                                                         output logic                 clamped);
      logic signed [IW:0]       r;
      logic signed [DATA_W-1:0] y;
      r = ((IW+1)'(v) + EXIT_HALF) >>> GUARD_BITS;
      if (r > OUT_MAX) begin
         y       = OUT_MAX[DATA_W-1:0];
         clamped = 1'b1;
      end else if (r < OUT_MIN) begin
         y       = OUT_MIN[DATA_W-1:0];
         clamped = 1'b1;
      end else begin
         y       = DATA_W'(r);
         clamped = 1'b0;
      end
      return y;
   endfunction

   logic                     vld_p0, vld_p1, vld_p2;
   logic                     rdy_p0, rdy_p1, rdy_p2;
   logic signed [IW-1:0]     x1_p0, x2_p0, x1_p1, x2_p1;
   logic signed [COEF_W-1:0] t_p0, s_p0, t_p1;
   logic [SIDE_W-1:0]        side_p0, side_p1, side_p2;
   logic signed [DATA_W-1:0] y1_p2, y2_p2;
   logic                     sat_p2;

   logic signed [COEF_W-1:0] tan_sel, sin_sel;
   logic signed [IW-1:0]     x1_in, x2_in, x1_s3;
   logic signed [DATA_W-1:0] y1_c, y2_c;
   logic                     sat1_c, sat2_c;

   // Out-of-range selects fall through to zero coefficients, i.e. identity.
   always_comb begin
      tan_sel = '0;
      sin_sel = '0;
      for (int k = 0; k < NUM_ANGLES; k++) begin
         if (s_angle_sel_i == ASW'(k)) begin
            tan_sel = TAN_COEFS[k*COEF_W +: COEF_W];
            sin_sel = SIN_COEFS[k*COEF_W +: COEF_W];
         end
      end
      if (s_inverse_i) begin
         tan_sel = -tan_sel;
         sin_sel = -sin_sel;
      end
   end

   assign x1_in = IW'(s_x1_i) <<< GUARD_BITS;
   assign x2_in = IW'(s_x2_i) <<< GUARD_BITS;

   assign rdy_p2    = !vld_p2 || m_ready_i;
   assign rdy_p1    = !vld_p1 || rdy_p2;
   assign rdy_p0    = !vld_p0 || rdy_p1;
   assign s_ready_o = rdy_p0;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         vld_p0 <= 1'b0;
         vld_p1 <= 1'b0;
         vld_p2 <= 1'b0;
      end else begin
         if (rdy_p0) vld_p0 <= s_valid_i;
         if (rdy_p1) vld_p1 <= vld_p0;
         if (rdy_p2) vld_p2 <= vld_p1;
      end
   end

   // Stage 1: x1 += T*x2
   always_ff @(posedge clk_i) begin
      if (rdy_p0 && s_valid_i) begin
         x1_p0   <= x1_in + mul_round(x2_in, tan_sel);
         x2_p0   <= x2_in;
         t_p0    <= tan_sel;
         s_p0    <= sin_sel;
         side_p0 <= s_side_data_i;
      end
   end

   // Stage 2: x2 -= S*x1
   always_ff @(posedge clk_i) begin
      if (rdy_p1 && vld_p0) begin
         x1_p1   <= x1_p0;
         x2_p1   <= x2_p0 - mul_round(x1_p0, s_p0);
         t_p1    <= t_p0;
         side_p1 <= side_p0;
      end
   end

   // Stage 3: x1 += T*x2, then drop guard bits and clamp
   always_comb begin
      x1_s3 = x1_p1 + mul_round(x2_p1, t_p1);
      y1_c  = exit_sat(x1_s3, sat1_c);
      y2_c  = exit_sat(x2_p1, sat2_c);
   end

   always_ff @(posedge clk_i) begin
      if (rdy_p2 && vld_p1) begin
         y1_p2   <= y1_c;
         y2_p2   <= y2_c;
         sat_p2  <= sat1_c | sat2_c;
         side_p2 <= side_p1;
      end
   end

   // Data registers are not reset; outputs read as zero whenever no beat is held.
   assign m_valid_o     = vld_p2;
   assign m_y1_o        = vld_p2 ? y1_p2 : '0;
   assign m_y2_o        = vld_p2 ? y2_p2 : '0;
   assign m_sat_o       = vld_p2 ? sat_p2 : 1'b0;
   assign m_side_data_o = vld_p2 ? side_p2 : '0;

endmodule
